// File: rtl/piso_pkg.sv
// Shared types and sizing helper for the parallel-in/serial-out shifter.
package piso_pkg;

   typedef enum logic {IDLE, SHIFT} piso_state_t;

   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_LOAD,
      SEL_SHIFT
   } cell_sel_t;

   // BITCNT must hold WIDTH-1; a 2-bit word still needs one counter bit.
   function automatic int bitcnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/dff_bit_cell.sv
// One shift-register bit: D flip-flop with async active-high clear and a load/shift/hold mux.
// Q updates one edge after the select is applied; hold keeps the stored bit.
module dff_bit_cell
   import piso_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_clr,
   input  cell_sel_t i_sel,
   input  logic      i_load_d,
   input  logic      i_shift_d,
   output logic      o_q
);

   logic r_q;
   logic w_d;

   always_comb begin
      w_d = r_q;
      case (i_sel)
         SEL_LOAD:  w_d = i_load_d;
         SEL_SHIFT: w_d = i_shift_d;
         default:   w_d = r_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         r_q <= 1'b0;
      end else begin
         r_q <= w_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/piso_serializer.sv
// Captures a WIDTH-bit word on LOAD and emits it one bit per ENABLE-high edge, LSB or MSB first.
// Bit 0 of the order is on SOUT the cycle after LOAD; ENABLE low stalls; DONE pulses after the last bit.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic                            i_load,
   input  logic [WIDTH-1:0]                i_din,
   input  logic                            i_sin,
   input  logic                            i_enable,
   output logic                            o_sout,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [bitcnt_width(WIDTH)-1:0]  o_bitcnt
);

   localparam int CNT_W = bitcnt_width(WIDTH);

   piso_state_t      r_state;
   logic [CNT_W-1:0] r_bitcnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_shift_d;
   cell_sel_t        w_sel;
   logic             w_busy;
   logic             w_accept;
   logic             w_advance;
   logic             w_last;

   assign w_busy    = (r_state == SHIFT);
   assign w_accept  = !w_busy && i_load;
   assign w_advance = w_busy && i_enable;
   assign w_last    = (r_bitcnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_sel = SEL_HOLD;
      if (w_accept) begin
         w_sel = SEL_LOAD;
      end else if (w_advance) begin
         w_sel = SEL_SHIFT;
      end
   end

   // Data moves toward the output end; the fill bit enters the opposite end.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shift_d = {w_q[WIDTH-2:0], i_sin};
      end else begin : g_lsb
         assign w_shift_d = {i_sin, w_q[WIDTH-1:1]};
      end
   endgenerate

   for (genvar b = 0; b < WIDTH; b++) begin : g_cell
      dff_bit_cell u_cell (
         .i_clk     (i_clock),
         .i_clr     (i_reset),
         .i_sel     (w_sel),
         .i_load_d  (i_din[b]),
         .i_shift_d (w_shift_d[b]),
         .o_q       (w_q[b])
      );
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_bitcnt <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_load) begin
                  r_state  <= SHIFT;
                  r_bitcnt <= '0;
               end
            end
            SHIFT: begin
               if (i_enable) begin
                  if (w_last) begin
                     r_state  <= IDLE;
                     r_bitcnt <= '0;
                     r_done   <= 1'b1;
                  end else begin
                     r_bitcnt <= r_bitcnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy   = w_busy;
   assign o_done   = r_done;
   assign o_bitcnt = r_bitcnt;
   assign o_sout   = w_busy & (MSB_FIRST ? w_q[WIDTH-1] : w_q[0]);

endmodule
